buff_uart_tx_arbiter: RTL
=========================

Name: buff_uart_tx_arbiter

Overview:
Round-robin scheduler that shares the buff_uart TX path between NUM_REQ requesters. Each requester offers bytes over valid/ready with a last flag marking burst end. The arbiter locks the grant for one burst and drives single-cycle write strobes onto the buff_uart bus at TX_ADDRESS. It sits between the client blocks and the buff_uart bus, replacing direct client access to active_address, read_enable and data.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
WIDTH, 8, data width; matches buff_uart width
ADDR_W, 8, width of bus_active_address
TX_ADDRESS, 4, bus address of the buff_uart TX buffer
GAP_CYCLES, 2, idle bus cycles after each strobe (0..15)
MAX_BURST, 16, beats per grant before forced rearbitration (1..255)
STALL_LIMIT, 8, watchdog threshold in cycles; used only with the optional feature

Ports:
clock  input  1  system clock, rising edge
resetn  input  1  synchronous active-low reset
req_valid  input  NUM_REQ  per-requester byte valid
req_last  input  NUM_REQ  per-requester last beat of burst
req_data  input  NUM_REQ*WIDTH  requester i data at [i*WIDTH +: WIDTH]
req_ready  output  NUM_REQ  per-requester accept; combinational
tx_space  input  1  buff_uart TX buffer can accept a byte
bus_active_address  output  ADDR_W  TX_ADDRESS during strobe, else 0
bus_read_enable  output  1  one-cycle strobe; buff_uart takes bus_data
bus_data  output  WIDTH  captured byte during strobe, else 0
grant  output  NUM_REQ  one-hot current grant; 0 in IDLE
busy  output  1  state != IDLE
stall_abort  output  1  one-cycle pulse on watchdog release; tied 0 without feature

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-low. While resetn=0 at a rising edge: state=IDLE, rr_ptr=0, all registered outputs=0, and the burst, gap and stall counters=0.
- Reset mid-burst abandons the burst. No strobe is issued on the cycle after reset.
- FSM states are IDLE, XFER, STROBE and GAP.
- IDLE: if any req_valid is set, grant the first index i with req_valid[i]=1, searching from rr_ptr upward modulo NUM_REQ. Set the grant register and go to XFER. Clear the burst counter.
- XFER: req_ready[g] = (state==XFER) & grant[g] & tx_space. Non-granted ready bits are 0.
- Handshake = req_valid[g] & req_ready[g]. On handshake, capture req_data and req_last, increment the burst counter, and go to STROBE.
- If tx_space=0, wait in XFER indefinitely. These cycles do not count toward the watchdog.
- STROBE lasts exactly one cycle:
  - bus_read_enable=1, bus_active_address=TX_ADDRESS, bus_data=captured byte.
  - Then go to GAP, or straight to the next-state rule below if GAP_CYCLES=0.
- GAP lasts GAP_CYCLES cycles with the bus outputs at 0. After GAP:
  - captured last=1 → IDLE, rr_ptr = g+1 mod NUM_REQ;
  - else burst counter == MAX_BURST → IDLE, rr_ptr = g+1 (forced fairness; the requester re-arbitrates later);
  - else → XFER with the same grant.
- Latency: req_valid high in IDLE at cycle t with tx_space=1 → grant at t+1, handshake at t+1, strobe at t+2.
- Throughput: one byte per 2+GAP_CYCLES cycles.
- Requester rule: req_data and req_last must stay stable while req_valid=1 and not yet accepted. req_valid must not drop mid-beat; it may drop between beats.
- Requests arriving in any state other than IDLE wait for the next IDLE arbitration.
- Simultaneous requests with all valid and rr_ptr=0 → grant order 0,1,2,3,0,…
- bus_read_enable is never high on two consecutive cycles.

Optional Feature:
Macro BUFF_UART_ARB_WATCHDOG_EN.
- Defined:
  - In XFER, count consecutive cycles with req_valid[g]=0 and tx_space=1.
  - When the count reaches STALL_LIMIT: go to IDLE, rr_ptr=g+1, pulse stall_abort for one cycle, drop the partial burst (already-strobed bytes stand).
  - The counter clears on handshake or on leaving XFER.
- Not defined: no counter; a stalled granted requester holds the grant forever; stall_abort is constant 0.

Test Plan:
1. Req0 sends 0x0A, last=1, GAP_CYCLES=2, tx_space=1, valid raised at cycle t → req_ready[0] at t+1; strobe at t+2 with address 4, data 0x0A, one cycle wide; busy low from t+5.
2. All 4 requesters each offer one byte (0x01..0x04, last=1) simultaneously → strobes carry 0x01,0x02,0x03,0x04 in that order, each separated by ≥2 idle bus cycles.
3. Req1 sends 3-beat burst 0x10,0x11,0x12 while req2 holds 0x20 pending → strobe order 0x10,0x11,0x12,0x20; grant never changes mid-burst.
4. tx_space=0 for 10 cycles while in XFER → req_ready=0 and no strobe throughout; after tx_space returns to 1, the byte is strobed 1 cycle after the handshake.
5. MAX_BURST=16, req0 streams 20 beats without last, req3 pending → after 16 strobes req3 is granted next; req0 resumes afterward.
6. With BUFF_UART_ARB_WATCHDOG_EN and STALL_LIMIT=8, req0 drops valid after beat 2 → stall_abort pulses 8 cycles later, FSM returns to IDLE, and a pending req1 is granted. Without the macro, the grant stays on req0. A reset pulse mid-burst gives all outputs 0 on the next cycle.

Source files
------------

// File: rtl/buff_uart_tx_arbiter.sv
// buff_uart_tx_arbiter
// Round-robin scheduler that shares the buff_uart TX path between NUM_REQ
// requesters. A grant is held for one burst (up to MAX_BURST beats). Each
// accepted byte is written to the bus as a single-cycle strobe at TX_ADDRESS,
// followed by GAP_CYCLES idle bus cycles.
// Optional feature: define BUFF_UART_ARB_WATCHDOG_EN to release a granted
// requester that stops offering data for STALL_LIMIT cycles while the TX
// buffer has space. This also produces a one-cycle stall_abort pulse.
module buff_uart_tx_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int WIDTH       = 8,
   parameter int ADDR_W      = 8,
   parameter int TX_ADDRESS  = 4,
   parameter int GAP_CYCLES  = 2,
   parameter int MAX_BURST   = 16,
   parameter int STALL_LIMIT = 8
) (
   input  logic                     clock,
   input  logic                     resetn,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ-1:0]       req_last,
   input  logic [NUM_REQ*WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic                     tx_space,
   output logic [ADDR_W-1:0]        bus_active_address,
   output logic                     bus_read_enable,
   output logic [WIDTH-1:0]         bus_data,
   output logic [NUM_REQ-1:0]       grant,
   output logic                     busy,
   output logic                     stall_abort
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_XFER   = 2'd1,
      S_STROBE = 2'd2,
      S_GAP    = 2'd3
   } state_e;

   state_e               state_q, state_d;
   logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]     gidx_q, gidx_d;
   logic [NUM_REQ-1:0]   grant_q, grant_d;
   logic [7:0]           burst_q, burst_d;
   logic [3:0]           gap_q, gap_d;
   logic                 last_q, last_d;
   logic [ADDR_W-1:0]    bus_addr_q;
   logic                 rd_en_q;
   logic [WIDTH-1:0]     bus_data_q;
   logic                 busy_q;

   logic [IDX_W-1:0]     sel_idx_s;
   logic                 sel_found_s;
   logic [IDX_W-1:0]     nxt_ptr_s;
   logic                 hs_s;
   logic                 cur_valid_s;
   logic                 cur_last_s;
   logic [WIDTH-1:0]     cur_data_s;
   logic                 burst_done_s;
   logic                 seq_end_s;

`ifdef BUFF_UART_ARB_WATCHDOG_EN
   logic [7:0]           stall_q, stall_d;
   logic                 abort_q, abort_d;
`endif

   // Only the granted requester sees ready, and only while the TX buffer has room
   assign req_ready    = ((state_q == S_XFER) && tx_space) ? grant_q : {NUM_REQ{1'b0}};
   assign hs_s         = |(req_valid & req_ready);
   assign cur_valid_s  = req_valid[gidx_q];
   assign cur_last_s   = req_last[gidx_q];
   assign cur_data_s   = req_data[gidx_q*WIDTH +: WIDTH];
   assign nxt_ptr_s    = (gidx_q == IDX_W'(NUM_REQ - 1)) ? {IDX_W{1'b0}} : gidx_q + IDX_W'(1);
   assign burst_done_s = last_q | (burst_q == 8'(MAX_BURST));

   // Round-robin pick: first valid index at or above rr_ptr, wrapping around
   always_comb begin
      int idx;
      idx         = 0;
      sel_found_s = 1'b0;
      sel_idx_s   = {IDX_W{1'b0}};
      // Scan from farthest to nearest so the nearest valid index wins
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx         = (int'(rr_ptr_q) + k) % NUM_REQ;
         sel_found_s = sel_found_s | req_valid[idx];
         sel_idx_s   = req_valid[idx] ? IDX_W'(idx) : sel_idx_s;
      end
   end

   // Next-state logic for the burst scheduler
   always_comb begin
      state_d   = state_q;
      rr_ptr_d  = rr_ptr_q;
      gidx_d    = gidx_q;
      grant_d   = grant_q;
      burst_d   = burst_q;
      gap_d     = gap_q;
      last_d    = last_q;
      seq_end_s = 1'b0;
`ifdef BUFF_UART_ARB_WATCHDOG_EN
      stall_d   = stall_q;
      abort_d   = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (sel_found_s) begin
               state_d = S_XFER;
               gidx_d  = sel_idx_s;
               grant_d = NUM_REQ'(1) << sel_idx_s;
               burst_d = 8'd0;
            end else begin
               grant_d = {NUM_REQ{1'b0}};
            end
         end
         S_XFER: begin
            if (hs_s) begin
               state_d = S_STROBE;
               last_d  = cur_last_s;
               burst_d = burst_q + 8'd1;
            end else begin
`ifdef BUFF_UART_ARB_WATCHDOG_EN
               // Stall cycles count only when the requester, not the TX buffer, is holding things up
               if (!cur_valid_s && tx_space) begin
                  if (({1'b0, stall_q} + 9'd1) == 9'(STALL_LIMIT)) begin
                     state_d  = S_IDLE;
                     grant_d  = {NUM_REQ{1'b0}};
                     rr_ptr_d = nxt_ptr_s;
                     abort_d  = 1'b1;
                  end else begin
                     stall_d = stall_q + 8'd1;
                  end
               end else if (cur_valid_s) begin
                  stall_d = 8'd0;
               end else begin
                  stall_d = stall_q;
               end
`else
               state_d = S_XFER;
`endif
            end
         end
         S_STROBE: begin
            if (GAP_CYCLES == 0) begin
               seq_end_s = 1'b1;
            end else begin
               state_d = S_GAP;
               gap_d   = 4'd0;
            end
         end
         S_GAP: begin
            if (gap_q == 4'(GAP_CYCLES - 1)) begin
               seq_end_s = 1'b1;
            end else begin
               gap_d = gap_q + 4'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
            grant_d = {NUM_REQ{1'b0}};
         end
      endcase
      // After a strobe (and its gap): end the burst or keep the grant for the next beat
      if (seq_end_s) begin
         if (burst_done_s) begin
            state_d  = S_IDLE;
            grant_d  = {NUM_REQ{1'b0}};
            rr_ptr_d = nxt_ptr_s;
         end else begin
            state_d = S_XFER;
         end
      end else begin
      end
`ifdef BUFF_UART_ARB_WATCHDOG_EN
      if (state_d != S_XFER) begin
         stall_d = 8'd0;
      end else begin
      end
`endif
   end

   // Scheduler state, grant and bookkeeping registers
   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_q  <= S_IDLE;
         rr_ptr_q <= {IDX_W{1'b0}};
         gidx_q   <= {IDX_W{1'b0}};
         grant_q  <= {NUM_REQ{1'b0}};
         burst_q  <= 8'd0;
         gap_q    <= 4'd0;
         last_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         gidx_q   <= gidx_d;
         grant_q  <= grant_d;
         burst_q  <= burst_d;
         gap_q    <= gap_d;
         last_q   <= last_d;
      end
   end

   // Bus outputs are registered so they are valid exactly during the STROBE cycle
   always_ff @(posedge clock) begin
      if (!resetn) begin
         bus_addr_q <= {ADDR_W{1'b0}};
         rd_en_q    <= 1'b0;
         bus_data_q <= {WIDTH{1'b0}};
         busy_q     <= 1'b0;
      end else begin
         bus_addr_q <= (state_d == S_STROBE) ? ADDR_W'(TX_ADDRESS) : {ADDR_W{1'b0}};
         rd_en_q    <= (state_d == S_STROBE);
         bus_data_q <= (state_d == S_STROBE) ? cur_data_s : {WIDTH{1'b0}};
         busy_q     <= (state_d != S_IDLE);
      end
   end

`ifdef BUFF_UART_ARB_WATCHDOG_EN
   // Stall counter and the one-cycle abort pulse
   always_ff @(posedge clock) begin
      if (!resetn) begin
         stall_q <= 8'd0;
         abort_q <= 1'b0;
      end else begin
         stall_q <= stall_d;
         abort_q <= abort_d;
      end
   end
   assign stall_abort = abort_q;
`else
   assign stall_abort = 1'b0;
`endif

   assign bus_active_address = bus_addr_q;
   assign bus_read_enable    = rd_en_q;
   assign bus_data           = bus_data_q;
   assign grant              = grant_q;
   assign busy               = busy_q;

endmodule
